// File: rtl/axi_pkg.sv
// Shared AXI burst definitions: burst-type codes, 4 KB page size and the
// splitter state encoding.
package axi_pkg;
   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
   localparam int         AXI_4KB         = 4096;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/axi_burst_calc.sv
// Beats for the next burst: INCR limited by remaining, MAX_BEATS and the 4 KB
// page edge; FIXED limited by remaining and 16. Purely combinational.
module axi_burst_calc
   import axi_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int MAX_BEATS = 16
) (
   input  logic [11:0]      i_addr_lo,
   input  logic [LEN_W-1:0] i_remaining,
   input  logic [1:0]       i_type,
   output logic [8:0]       o_beats,
   output logic             o_bind4k
);
   localparam int CW = (LEN_W > 13) ? LEN_W : 13;

   logic [12:0]   w_room;
   logic [CW-1:0] w_rem, w_cap, w_room_x, w_lim, w_incr, w_fixed;

   // 13-bit so a page-aligned address yields 1024 beats rather than 0
   assign w_room   = (13'(AXI_4KB) - {1'b0, i_addr_lo}) >> 2;
   assign w_rem    = CW'(i_remaining);
   assign w_cap    = CW'(MAX_BEATS);
   assign w_room_x = CW'(w_room);
   assign w_lim    = (w_rem < w_cap) ? w_rem : w_cap;
   assign w_incr   = (w_room_x < w_lim) ? w_room_x : w_lim;
   assign w_fixed  = (w_rem < CW'(16)) ? w_rem : CW'(16);

   assign o_beats  = 9'((i_type == AXI_BURST_INCR) ? w_incr : w_fixed);
   assign o_bind4k = (i_type == AXI_BURST_INCR) && (w_room_x < w_lim);
endmodule

// File: rtl/axi_burst_splitter.sv
// Splits word transfer requests into legal AXI4 burst commands and tracks
// outstanding bursts. AXI_BURST_SPLITTER_STATS_EN adds burst/4 KB-split counters.
module axi_burst_splitter
   import axi_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int LEN_W           = 16,
   parameter int MAX_BEATS       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_beats,
   input  logic [1:0]        req_type,
   output logic              req_err,
   output logic              req_done,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [7:0]        cmd_burst_len,
   output logic [1:0]        cmd_burst_type,
   output logic              cmd_last,
   input  logic              burst_done,
   output logic              busy
`ifdef AXI_BURST_SPLITTER_STATS_EN
   ,
   output logic [31:0]       stat_bursts,
   output logic [31:0]       stat_4k_splits
`endif
);
   state_t            r_state, w_state_nxt;
   logic              r_wr, r_err, r_bind, w_bind;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [LEN_W-1:0]  r_rem, w_rem_nxt;
   logic [1:0]        r_type, w_type_nxt;
   logic [8:0]        r_beats, w_beats;
   logic [7:0]        r_len;
   logic [3:0]        r_out;
   logic              w_legal, w_take, w_acc, w_dec, w_load;

   assign w_legal = (req_beats != '0) && (req_addr[1:0] == 2'b00) && !req_type[1];
   assign w_acc   = cmd_valid && cmd_ready;
   assign w_dec   = burst_done && (r_out != 4'd0);
   // Burst size is precomputed from the next-cycle address/remaining so the
   // command fields come straight from registers.
   assign w_load  = w_take || (w_acc && !cmd_last);

   axi_burst_calc #(.LEN_W(LEN_W), .MAX_BEATS(MAX_BEATS)) u_calc (
      .i_addr_lo   (w_addr_nxt[11:0]),
      .i_remaining (w_rem_nxt),
      .i_type      (w_type_nxt),
      .o_beats     (w_beats),
      .o_bind4k    (w_bind)
   );

   assign req_ready      = (r_state == ST_IDLE);
   assign busy           = (r_state != ST_IDLE);
   assign req_err        = r_err;
   assign req_done       = (r_state == ST_DRAIN) && (r_out == 4'd0);
   assign cmd_valid      = (r_state == ST_ISSUE) && (r_out < 4'(MAX_OUTSTANDING));
   assign cmd_last       = (r_state == ST_ISSUE) && (r_rem == LEN_W'(r_beats));
   assign cmd_wr         = r_wr;
   assign cmd_addr       = r_addr;
   assign cmd_burst_len  = r_len;
   assign cmd_burst_type = r_type;

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_rem_nxt   = r_rem;
      w_type_nxt  = r_type;
      w_take      = 1'b0;
      case (r_state)
         ST_IDLE: if (req_valid && w_legal) begin
            w_take      = 1'b1;
            w_addr_nxt  = req_addr;
            w_rem_nxt   = req_beats;
            w_type_nxt  = req_type;
            w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: if (w_acc) begin
            w_rem_nxt = r_rem - LEN_W'(r_beats);
            if (r_type == AXI_BURST_INCR)
               w_addr_nxt = r_addr + ADDR_W'({r_beats, 2'b00});
            if (cmd_last)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (r_out == 4'd0) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_err   <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_rem   <= '0;
         r_type  <= 2'b00;
         r_beats <= 9'd0;
         r_len   <= 8'd0;
         r_bind  <= 1'b0;
         r_out   <= 4'd0;
      end else begin
         r_err  <= (r_state == ST_IDLE) && req_valid && !w_legal;
         if (w_take) r_wr <= req_wr;
         r_addr <= w_addr_nxt;
         r_rem  <= w_rem_nxt;
         r_type <= w_type_nxt;
         if (w_load) begin
            r_beats <= w_beats;
            r_len   <= 8'(w_beats - 9'd1);
            r_bind  <= w_bind;
         end
         r_out <= r_out + 4'(w_acc) - 4'(w_dec);
      end
   end

`ifdef AXI_BURST_SPLITTER_STATS_EN
   logic [31:0] r_stat_bursts, r_stat_4k;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_stat_bursts <= 32'd0;
         r_stat_4k     <= 32'd0;
      end else begin
         r_stat_bursts <= r_stat_bursts + 32'(w_acc);
         r_stat_4k     <= r_stat_4k + 32'(w_acc && r_bind);
      end
   end

   assign stat_bursts    = r_stat_bursts;
   assign stat_4k_splits = r_stat_4k;
`endif
endmodule

// File: tb/tb_axi_burst_splitter.sv
// Randomized scoreboard bench for axi_burst_splitter: a reference model expands
// each request into its expected burst list; a monitor checks every cycle.
`timescale 1ns/1ps
module tb_axi_burst_splitter;
   import axi_pkg::*;

   localparam int ADDR_W    = 32;
   localparam int LEN_W     = 16;
   localparam int MAX_BEATS = 16;
   localparam int MAX_OUT   = 2;

   logic              clk = 1'b0;
   logic              resetn;
   logic              req_valid, req_ready, req_wr, req_err, req_done;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_beats;
   logic [1:0]        req_type;
   logic              cmd_valid, cmd_ready, cmd_wr, cmd_last, burst_done, busy;
   logic [ADDR_W-1:0] cmd_addr;
   logic [7:0]        cmd_burst_len;
   logic [1:0]        cmd_burst_type;
`ifdef AXI_BURST_SPLITTER_STATS_EN
   logic [31:0]       stat_bursts, stat_4k_splits;
`endif

   axi_burst_splitter #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BEATS(MAX_BEATS), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_beats(req_beats), .req_type(req_type),
      .req_err(req_err), .req_done(req_done),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_burst_len(cmd_burst_len),
      .cmd_burst_type(cmd_burst_type), .cmd_last(cmd_last),
      .burst_done(burst_done), .busy(busy)
`ifdef AXI_BURST_SPLITTER_STATS_EN
      , .stat_bursts(stat_bursts), .stat_4k_splits(stat_4k_splits)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic        last;
      logic [1:0]  typ;
      logic        wr;
      logic        bind4k;
   } cmd_t;

   cmd_t        q[$];
   cmd_t        mc;
   int          vecs = 0, errs = 0;
   int          tb_out = 0;
   bit          req_active = 0, err_pend = 0, exp_done = 0;
   bit          mon_en = 0, drv_en = 0, drv_hold = 0;
   bit          dn;
   int unsigned tb_bursts = 0, tb_4k = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      vecs++;
      errs++;
      $display("FAIL %s: event seen/absent contrary to model", name);
   endtask

   // Expected burst list straight from the splitting rules.
   task automatic model(input bit wr, input logic [31:0] a, input int beats, input logic [1:0] t);
      int rem, n, room, lim;
      logic [31:0] ad;
      cmd_t c;
      rem = beats;
      ad  = a;
      while (rem > 0) begin
         room = (4096 - int'(ad % 32'd4096)) / 4;
         lim  = (rem < MAX_BEATS) ? rem : MAX_BEATS;
         if (t == AXI_BURST_INCR) n = (room < lim) ? room : lim;
         else                     n = (rem < 16) ? rem : 16;
         c.addr   = ad;
         c.len    = 8'(n - 1);
         c.last   = (n == rem);
         c.typ    = t;
         c.wr     = wr;
         c.bind4k = (t == AXI_BURST_INCR) && (room < lim);
         q.push_back(c);
         rem -= n;
         if (t == AXI_BURST_INCR) ad = ad + 32'(n * 4);
      end
   endtask

   task automatic send(input bit wr, input logic [31:0] a, input logic [15:0] b, input logic [1:0] t);
      int n;
      bit legal;
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_beats = b; req_type = t;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 2000);
      if (!req_ready) fail_evt("req_accept_timeout");
      @(posedge clk);
      legal = (b != 0) && (a[1:0] == 2'b00) && (t < 2);
      if (legal) begin
         model(wr, a, int'(b), t);
         req_active = 1'b1;
      end else begin
         err_pend = 1'b1;
      end
      #1 req_valid = 1'b0;
      n = 0;
      while ((req_active || err_pend) && n < 5000) begin @(negedge clk); n++; end
      if (req_active || err_pend) fail_evt("req_complete_timeout");
   endtask

   // Master model: random cmd_ready and completions, plus stray completions when idle.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (drv_en) begin
            if (drv_hold) begin
               cmd_ready  = 1'b0;
               burst_done = 1'b0;
            end else begin
               cmd_ready  = ($urandom_range(0, 3) != 0);
               burst_done = (tb_out > 0) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 7) == 0);
            end
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("req_ready", req_ready, !req_active);
            chk("busy", busy, req_active);
            chk("req_err", req_err, err_pend);
            err_pend = 1'b0;
            chk("req_done", req_done, exp_done);
            if (exp_done) begin req_active = 1'b0; exp_done = 1'b0; end
            chk("cmd_valid", cmd_valid, (q.size() > 0) && (tb_out < MAX_OUT));
`ifdef AXI_BURST_SPLITTER_STATS_EN
            chk("stat_bursts", stat_bursts, tb_bursts);
            chk("stat_4k_splits", stat_4k_splits, tb_4k);
`endif
            dn = burst_done && (tb_out > 0);
            if (cmd_valid && cmd_ready) begin
               if (q.size() == 0) fail_evt("unexpected_cmd");
               else begin
                  mc = q.pop_front();
                  chk("cmd_addr", cmd_addr, mc.addr);
                  chk("cmd_burst_len", cmd_burst_len, mc.len);
                  chk("cmd_last", cmd_last, mc.last);
                  chk("cmd_burst_type", cmd_burst_type, mc.typ);
                  chk("cmd_wr", cmd_wr, mc.wr);
                  tb_bursts++;
                  if (mc.bind4k) tb_4k++;
               end
               tb_out++;
            end
            if (dn) tb_out--;
            exp_done = req_active && (q.size() == 0) && (tb_out == 0);
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [15:0] b;
      logic [1:0]  t;
      int          k;
      req_valid = 0; req_wr = 0; req_addr = '0; req_beats = '0; req_type = 2'b00;
      cmd_ready = 0; burst_done = 1'b1; resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_cmd_valid", cmd_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_err", req_err, 1'b0);
      chk("rst_req_done", req_done, 1'b0);
      chk("rst_cmd_last", cmd_last, 1'b0);
      chk("rst_cmd_addr", cmd_addr, 32'h0);
      chk("rst_cmd_len", cmd_burst_len, 8'h0);
      chk("rst_cmd_type", cmd_burst_type, 2'b00);
      chk("rst_cmd_wr", cmd_wr, 1'b0);
      @(posedge clk); #1;
      resetn = 1'b1; burst_done = 1'b0; mon_en = 1'b1; drv_en = 1'b1;

      send(1'b1, 32'h0000_0100, 16'd40, AXI_BURST_INCR);
      send(1'b0, 32'h0000_0FF0, 16'd10, AXI_BURST_INCR);
      send(1'b1, 32'h0000_0020, 16'd20, AXI_BURST_FIXED);
      send(1'b0, 32'h0000_0000, 16'd0,  AXI_BURST_INCR);
      send(1'b0, 32'h0000_0003, 16'd4,  AXI_BURST_INCR);
      send(1'b0, 32'h0000_0040, 16'd4,  AXI_BURST_WRAP);
      send(1'b1, 32'hFFFF_FFC0, 16'd40, AXI_BURST_INCR);
      send(1'b0, 32'h0000_0000, 16'd64, AXI_BURST_INCR);
      send(1'b1, 32'h0000_3000, 16'd300, AXI_BURST_INCR);

      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         a[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(1, 64);
            a[11:0] = 12'(4096 - 4 * k);
         end
         b = 16'($urandom_range(1, 80));
         t = 2'($urandom_range(0, 1));
         case ($urandom_range(0, 12))
            0:       b = 16'd0;
            1:       a[0] = 1'b1;
            2:       t = 2'($urandom_range(2, 3));
            default: ;
         endcase
         send(1'($urandom_range(0, 1)), a, b, t);
      end

      // Reset while a command is being offered.
      @(posedge clk); #1;
      mon_en = 1'b0; drv_hold = 1'b1;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0; req_beats = 16'd64;
      req_type = AXI_BURST_INCR;
      @(negedge clk);
      chk("mid_rst_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_cmd_valid_pre", cmd_valid, 1'b1);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("mid_rst_cmd_valid", cmd_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_req_ready", req_ready, 1'b1);
      q.delete();
      tb_out = 0; req_active = 0; err_pend = 0; exp_done = 0;
      tb_bursts = 0; tb_4k = 0;
      mon_en = 1'b1; drv_hold = 1'b0;
      send(1'b0, 32'h0000_2000, 16'd20, AXI_BURST_INCR);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/axi_burst_splitter.md
Name: axi_burst_splitter

Overview:
- Upstream command stage for the AXI full master wrapper.
- Takes arbitrary-length word transfer requests and issues a sequence of legal AXI4 burst commands on the master's user command port (wr / addr / burst_len / burst_type).
- INCR bursts are limited to MAX_BEATS and never cross a 4 KB boundary.
- Outstanding bursts are tracked against completions from the master: write response, or read last beat.

Parameters:
- ADDR_W, 32, address width.
- LEN_W, 16, width of the request beat count.
- MAX_BEATS, 16, maximum beats per INCR burst; legal range 1..256.
- MAX_OUTSTANDING, 4, maximum issued-but-uncompleted bursts; legal range 1..15.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high together with req_valid.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start byte address; must be 4-byte aligned.
- req_beats  in  LEN_W  total 32-bit beats; 0 is illegal.
- req_type  in  2  2'b00 FIXED, 2'b01 INCR; 2'b10/2'b11 illegal.
- req_err  out  1  one-cycle pulse when an illegal request is rejected.
- req_done  out  1  one-cycle pulse when all bursts of the current request have completed.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  master accepts the command.
- cmd_wr  out  1  direction of the burst.
- cmd_addr  out  ADDR_W  burst start address.
- cmd_burst_len  out  8  AXI len, i.e. beats-1.
- cmd_burst_type  out  2  copied from req_type.
- cmd_last  out  1  marks the final burst of the request.
- burst_done  in  1  one-cycle completion pulse from the master (bvalid&bready or rlast&rvalid&rready).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (resetn low at posedge): state=IDLE; outstanding=0; all outputs 0 except req_ready=1.
- Reset mid-operation abandons the request; burst_done pulses arriving while in reset are ignored.
- States:
  - IDLE: req_ready=1.
    - On req_valid with an illegal request (beats==0, addr[1:0]!=0, or type>=2): pulse req_err next cycle, stay IDLE, no cmd issued.
    - On a legal request: latch wr/addr/beats/type into cur_addr/remaining, go to ISSUE.
  - ISSUE: req_ready=0.
    - Compute beats_now:
      - INCR: min(remaining, MAX_BEATS, (4096 - cur_addr[11:0]) >> 2).
      - FIXED: min(remaining, 16).
    - cmd_valid=1 only when outstanding < MAX_OUTSTANDING; command fields are registered and stable while cmd_valid && !cmd_ready.
    - On cmd_valid && cmd_ready:
      - outstanding += 1; remaining -= beats_now.
      - INCR: cur_addr += beats_now<<2. FIXED: cur_addr unchanged.
      - If remaining reaches 0 (cmd_last=1): go to DRAIN; else stay in ISSUE, with the next command presentable the following cycle.
  - DRAIN: wait until outstanding==0, then pulse req_done for one cycle and go to IDLE. req_ready returns to 1 the cycle after req_done.
- Outstanding counter:
  - burst_done decrements it.
  - Simultaneous accept and burst_done in the same cycle leaves it unchanged.
  - burst_done when outstanding==0 is ignored (saturate at 0, no underflow).
- Arithmetic:
  - The 4 KB computation uses 13-bit unsigned arithmetic; at cur_addr[11:0]==0 it yields 1024 beats, which is then clipped by MAX_BEATS.
  - cmd_burst_len = beats_now-1, truncated to 8 bits (beats_now <= 256 by construction).
  - cur_addr wraps modulo 2^ADDR_W with no error.
- Latency:
  - First cmd_valid appears 1 cycle after request acceptance.
  - req_done appears 1 cycle after the final burst_done.

Optional Feature:
- AXI_BURST_SPLITTER_STATS_EN defined:
  - Adds outputs stat_bursts[31:0] (commands accepted) and stat_4k_splits[31:0] (INCR commands where the 4 KB limit was the binding term).
  - Both are free-running, wrap at 2^32, and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package axi_pkg holds:
  - Burst-type constants AXI_BURST_FIXED=2'b00, AXI_BURST_INCR=2'b01, AXI_BURST_WRAP=2'b10.
  - AXI_4KB=4096 and the state encoding (IDLE/ISSUE/DRAIN).
- One natural sub-module: axi_burst_calc, a combinational beats_now computation taking cur_addr, remaining, type and MAX_BEATS. It is reused later by the read/write DMA.

Test Plan:
- INCR 0x0000_0100, 40 beats, cmd_ready=1 -> cmds (0x100,len 15),(0x140,len 15),(0x180,len 7, cmd_last=1); req_done 1 cycle after the 3rd burst_done.
- INCR 0x0000_0FF0, 10 beats -> (0xFF0,len 3),(0x1000,len 5,last); with STATS_EN, stat_4k_splits=1 and stat_bursts=2.
- FIXED 0x20, 20 beats -> (0x20,len 15),(0x20,len 3,last); both commands carry cmd_burst_type=2'b00.
- Illegal requests: beats=0, addr=0x3, and type=2'b10, each sent separately -> one req_err pulse per request, cmd_valid never asserts, req_ready stays 1.
- MAX_OUTSTANDING=2, INCR 0x0, 64 beats, burst_done held low -> exactly 2 commands accepted, then cmd_valid=0. One burst_done pulse -> the 3rd command issues within 1 cycle. burst_done in the same cycle as a command accept -> outstanding unchanged.
- resetn low for 1 cycle during ISSUE with cmd_valid=1 -> the next cycle shows cmd_valid=0, busy=0, req_ready=1, and a new request is accepted normally.
